// File: rtl/switch_control_if.sv
// Header request / crossbar select bundle between the five input buffers
// and the per-router allocation block.
interface switch_control_if #(
  parameter int NPORT   = 5,
  parameter int COORD_W = 4
);
  logic [NPORT-1:0]           h;
  logic [NPORT*2*COORD_W-1:0] target;
  logic [NPORT-1:0]           sender;
  logic [NPORT-1:0]           ack_h;
  logic [NPORT-1:0]           free;
  logic [NPORT*3-1:0]         mux_in;
  logic [NPORT*3-1:0]         mux_out;

  // Input-buffer side: raises requests, observes grants and crossbar selects.
  modport master (
    output h, target, sender,
    input  ack_h, free, mux_in, mux_out
  );

  // Allocator side.
  modport slave (
    input  h, target, sender,
    output ack_h, free, mux_in, mux_out
  );
endinterface

// File: rtl/switch_control.sv
// Phoenix NoC switch control: round-robin header arbitration, XY routing
// against this router's address, output reservation and release.
module switch_control #(
  parameter int                     NPORT   = 5,
  parameter int                     COORD_W = 4,
  parameter logic [2*COORD_W-1:0]   ADDRESS = 8'h11
) (
  input logic            clock,
  input logic            reset,
  switch_control_if.slave sw
);

  localparam int IDX_W = 3;
  localparam int TGT_W = 2*COORD_W;

  typedef logic [IDX_W-1:0] ptr_t;

  localparam ptr_t EAST  = 3'd0;
  localparam ptr_t WEST  = 3'd1;
  localparam ptr_t NORTH = 3'd2;
  localparam ptr_t SOUTH = 3'd3;
  localparam ptr_t LOCAL = 3'd4;

  localparam logic [COORD_W-1:0] LX = ADDRESS[TGT_W-1:COORD_W];
  localparam logic [COORD_W-1:0] LY = ADDRESS[COORD_W-1:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARB,
    S_ROUTE,
    S_ACK
  } state_t;

  state_t           state_q, state_d;
  ptr_t             last_q, last_d;
  ptr_t             sel_q, sel_d;
  logic [NPORT-1:0] ack_q, ack_d;
  logic [NPORT-1:0] free_q, free_d;
  ptr_t             mux_in_q  [NPORT];
  ptr_t             mux_in_d  [NPORT];
  ptr_t             mux_out_q [NPORT];
  ptr_t             mux_out_d [NPORT];

  logic [TGT_W-1:0]   tgt_a [NPORT];
  logic [TGT_W-1:0]   tgt_sel;
  logic [COORD_W-1:0] tx, ty;
  ptr_t               route_dir;
  ptr_t               cand;
  ptr_t               pick_idx;
  logic               pick_found;

  for (genvar g = 0; g < NPORT; g++) begin : g_flat
    assign tgt_a[g]                          = sw.target[g*TGT_W +: TGT_W];
    assign sw.mux_in[g*IDX_W +: IDX_W]       = mux_in_q[g];
    assign sw.mux_out[g*IDX_W +: IDX_W]      = mux_out_q[g];
  end

  assign sw.ack_h = ack_q;
  assign sw.free  = free_q;

  // Round-robin pick: scan last+1 .. last (wrapping); nearest requester wins.
  always_comb begin
    pick_found = |sw.h;
    pick_idx   = last_q;
    cand       = last_q;
    // Descending scan so the final assignment is the closest successor of last.
    for (int unsigned k = NPORT; k >= 1; k--) begin
      cand = ptr_t'((32'(last_q) + k) % NPORT);
      if (sw.h[cand]) pick_idx = cand;
    end
  end

  // XY route of the selected header: resolve X first, then Y, else local.
  always_comb begin
    tgt_sel   = tgt_a[sel_q];
    tx        = tgt_sel[TGT_W-1:COORD_W];
    ty        = tgt_sel[COORD_W-1:0];
    route_dir = LOCAL;
    if (tx > LX)      route_dir = EAST;
    else if (tx < LX) route_dir = WEST;
    else if (ty > LY) route_dir = NORTH;
    else if (ty < LY) route_dir = SOUTH;
  end

  // Next state: per-cycle output release plus the allocation FSM.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    sel_d     = sel_q;
    ack_d     = '0;
    free_d    = free_q;
    mux_in_d  = mux_in_q;
    mux_out_d = mux_out_q;

    for (int unsigned o = 0; o < NPORT; o++) begin
      if (!free_q[o] && !sw.sender[mux_in_q[o]]) free_d[o] = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (|sw.h) state_d = S_ARB;
      end
      S_ARB: begin
        if (pick_found) begin
          sel_d   = pick_idx;
          last_d  = pick_idx;
          state_d = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        // Release never touches route_dir here because it only acts on busy outputs.
        if (free_q[route_dir]) begin
          free_d[route_dir]    = 1'b0;
          mux_in_d[route_dir]  = sel_q;
          mux_out_d[sel_q]     = route_dir;
          ack_d[sel_q]         = 1'b1;
          state_d              = S_ACK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      last_q    <= ptr_t'(NPORT-1);
      sel_q     <= '0;
      ack_q     <= '0;
      free_q    <= '1;
      mux_in_q  <= '{default: '0};
      mux_out_q <= '{default: '0};
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      free_q    <= free_d;
      mux_in_q  <= mux_in_d;
      mux_out_q <= mux_out_d;
    end
  end

endmodule

// File: tb/tb_switch_control.sv
// Bench for switch_control: transaction-level model of round-robin pick,
// XY routing and output ownership, with randomized targets and ports.
module tb_switch_control;
  localparam int          NPORT   = 5;
  localparam int          COORD_W = 4;
  localparam logic [7:0]  ADDR    = 8'h11;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_control_if #(.NPORT(NPORT), .COORD_W(COORD_W)) bus ();

  switch_control #(.NPORT(NPORT), .COORD_W(COORD_W), .ADDRESS(ADDR)) dut (
    .clock (clk),
    .reset (rst_n),
    .sw    (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_last;
  logic [7:0] tgt_m [NPORT];

  function automatic int route(input logic [7:0] t);
    int tx, ty, lx, ly;
    tx = int'(t[7:4]); ty = int'(t[3:0]);
    lx = int'(ADDR[7:4]); ly = int'(ADDR[3:0]);
    if (tx > lx) return 0;
    if (tx < lx) return 1;
    if (ty > ly) return 2;
    if (ty < ly) return 3;
    return 4;
  endfunction

  function automatic int rr_pick(input logic [4:0] hv, input int last);
    for (int k = 1; k <= NPORT; k++) begin
      int i;
      i = (last + k) % NPORT;
      if (hv[i]) return i;
    end
    return -1;
  endfunction

  function automatic int mux_of(input logic [14:0] v, input int i);
    logic [2:0] f;
    f = v[i*3 +: 3];
    return int'(f);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int maxc, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (bus.ack_h == '0 && cyc < maxc);
  endtask

  task automatic request(input int p, input logic [7:0] t);
    bus.target[p*8 +: 8] = t;
    tgt_m[p]      = t;
    bus.h[p]      = 1'b1;
    bus.sender[p] = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.h      = 5'($urandom);
      bus.target = 40'({$urandom, $urandom});
      bus.sender = 5'($urandom);
      tick();
      n_vec++;
      if ({bus.ack_h, bus.free, bus.mux_in, bus.mux_out} !== {5'b0, 5'b11111, 15'b0, 15'b0}) begin
        n_err++;
        $display("FAIL reset_state: ack=%b free=%b mux_in=%h mux_out=%h, want ack=0 free=11111 mux=0",
                 bus.ack_h, bus.free, bus.mux_in, bus.mux_out);
      end
    end
    bus.h = '0; bus.sender = '0; bus.target = '0;
    rst_n = 1'b1;
    exp_last = NPORT - 1;
    tick();
  endtask

  task automatic test_first_grant();
    logic [4:0] e;
    request(4, 8'h31);
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 3) ? 5'b10000 : 5'b00000;
      n_vec++;
      if (bus.ack_h !== e) begin
        n_err++;
        $display("FAIL first_latency edge%0d: ack=%b want %b", c, bus.ack_h, e);
      end
    end
    n_vec++;
    if (mux_of(bus.mux_in, 0) != 4 || mux_of(bus.mux_out, 4) != 0 || bus.free !== 5'b11110) begin
      n_err++;
      $display("FAIL first_alloc: mux_in[0]=%0d mux_out[4]=%0d free=%b want 4 0 11110",
               mux_of(bus.mux_in, 0), mux_of(bus.mux_out, 4), bus.free);
    end
    exp_last = 4;
    bus.h[4] = 1'b0;
    tick();
    n_vec++;
    if (bus.ack_h !== 5'b0) begin
      n_err++;
      $display("FAIL ack_width: ack=%b want 00000", bus.ack_h);
    end
    bus.sender[4] = 1'b0;
    tick();
    n_vec++;
    if (bus.free !== 5'b11111) begin
      n_err++;
      $display("FAIL first_release: free=%b want 11111", bus.free);
    end
  endtask

  task automatic test_routing();
    int         pl [11];
    logic [7:0] tl [11];
    logic [7:0] fixed [5];
    int         cyc, d, p;
    logic [4:0] e;
    fixed = '{8'h01, 8'h13, 8'h10, 8'h11, 8'h33};
    for (int i = 0; i < 6; i++) begin
      pl[i] = $urandom_range(0, NPORT-1);
      if (i == 5) tl[i] = 8'($urandom);
      else        tl[i] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
    end
    for (int i = 0; i < 5; i++) begin
      pl[6+i] = 4;
      tl[6+i] = fixed[i];
    end
    for (int i = 0; i < 11; i++) begin
      p = pl[i];
      request(p, tl[i]);
      wait_ack(8, cyc);
      e = 5'(1 << p);
      n_vec++;
      if (bus.ack_h !== e || cyc != 3) begin
        n_err++;
        $display("FAIL route_ack t=%h: ack=%b after %0d edges want %b after 3", tl[i], bus.ack_h, cyc, e);
      end
      d = route(tl[i]);
      n_vec++;
      if (mux_of(bus.mux_in, d) != p || mux_of(bus.mux_out, p) != d || bus.free !== (5'b11111 & ~5'(1 << d))) begin
        n_err++;
        $display("FAIL route_dir t=%h in=%0d: mux_in[%0d]=%0d mux_out=%0d free=%b want dir %0d",
                 tl[i], p, d, mux_of(bus.mux_in, d), mux_of(bus.mux_out, p), bus.free, d);
      end
      exp_last = p;
      bus.h[p] = 1'b0;
      tick();
      bus.sender[p] = 1'b0;
      tick();
      n_vec++;
      if (bus.free !== 5'b11111) begin
        n_err++;
        $display("FAIL route_release t=%h: free=%b want 11111", tl[i], bus.free);
      end
    end
  endtask

  task automatic test_fairness();
    logic [7:0] dtab [5];
    logic [4:0] hv, exp_free, e;
    int a, b, cyc, ep, d;
    dtab = '{8'h31, 8'h01, 8'h13, 8'h10, 8'h11};
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin a = 0; b = 1; end
      else begin
        a = $urandom_range(0, 4);
        b = (a + 1 + $urandom_range(0, 3)) % 5;
      end
      request(0, dtab[a]);
      request(1, dtab[b]);
      hv = 5'b00011;
      exp_free = 5'b11111;
      for (int g = 0; g < 2; g++) begin
        ep = rr_pick(hv, exp_last);
        wait_ack(8, cyc);
        e = 5'(1 << ep);
        n_vec++;
        if (bus.ack_h !== e || cyc != ((g == 0) ? 3 : 4) || ep != g) begin
          n_err++;
          $display("FAIL fair r%0d g%0d: ack=%b after %0d edges want %b after %0d",
                   r, g, bus.ack_h, cyc, e, (g == 0) ? 3 : 4);
        end
        d = route(tgt_m[ep]);
        exp_free[d] = 1'b0;
        n_vec++;
        if (mux_of(bus.mux_in, d) != ep || bus.free !== exp_free) begin
          n_err++;
          $display("FAIL fair_alloc r%0d g%0d: mux_in[%0d]=%0d free=%b want %0d %b",
                   r, g, d, mux_of(bus.mux_in, d), bus.free, ep, exp_free);
        end
        exp_last = ep;
        hv[ep] = 1'b0;
        bus.h[ep] = 1'b0;
      end
      tick();
      bus.sender[0] = 1'b0;
      bus.sender[1] = 1'b0;
      tick();
      n_vec++;
      if (bus.free !== 5'b11111) begin
        n_err++;
        $display("FAIL fair_release r%0d: free=%b want 11111", r, bus.free);
      end
    end
  endtask

  task automatic test_blocking();
    int cyc;
    request(4, 8'h31);
    wait_ack(8, cyc);
    n_vec++;
    if (bus.ack_h !== 5'b10000) begin
      n_err++;
      $display("FAIL block_setup: ack=%b want 10000", bus.ack_h);
    end
    exp_last = 4;
    bus.h[4] = 1'b0;
    tick();
    request(1, 8'h3F);
    for (int c = 0; c < 16; c++) begin
      tick();
      n_vec++;
      if (bus.ack_h !== 5'b0 || bus.free[0] !== 1'b0) begin
        n_err++;
        $display("FAIL blocked c%0d: ack=%b free=%b want ack 00000 free[0]=0", c, bus.ack_h, bus.free);
      end
    end
    bus.sender[4] = 1'b0;
    tick();
    n_vec++;
    if (bus.free[0] !== 1'b1 || bus.ack_h !== 5'b0) begin
      n_err++;
      $display("FAIL block_release: free=%b ack=%b want free[0]=1 ack 0", bus.free, bus.ack_h);
    end
    wait_ack(8, cyc);
    n_vec++;
    if (bus.ack_h !== 5'b00010 || mux_of(bus.mux_in, 0) != 1 || mux_of(bus.mux_out, 1) != 0 || bus.free !== 5'b11110) begin
      n_err++;
      $display("FAIL block_grant: ack=%b mux_in[0]=%0d mux_out[1]=%0d free=%b want 00010 1 0 11110",
               bus.ack_h, mux_of(bus.mux_in, 0), mux_of(bus.mux_out, 1), bus.free);
    end
    exp_last = 1;
    bus.h[1] = 1'b0;
    tick();
    bus.sender[1] = 1'b0;
    tick();
    n_vec++;
    if (bus.free !== 5'b11111) begin
      n_err++;
      $display("FAIL block_cleanup: free=%b want 11111", bus.free);
    end
  endtask

  task automatic test_concurrent();
    int cyc;
    request(4, 8'h31);
    wait_ack(8, cyc);
    bus.h[4] = 1'b0;
    exp_last = 4;
    tick();
    request(2, 8'h13);
    tick();
    tick();
    bus.sender[4] = 1'b0;
    tick();
    n_vec++;
    if (bus.ack_h !== 5'b00100 || bus.free !== 5'b11011 ||
        mux_of(bus.mux_in, 2) != 2 || mux_of(bus.mux_out, 2) != 2) begin
      n_err++;
      $display("FAIL concurrent: ack=%b free=%b mux_in[2]=%0d mux_out[2]=%0d want 00100 11011 2 2",
               bus.ack_h, bus.free, mux_of(bus.mux_in, 2), mux_of(bus.mux_out, 2));
    end
    exp_last = 2;
    bus.h[2] = 1'b0;
    tick();
    bus.sender[2] = 1'b0;
    tick();
    n_vec++;
    if (bus.free !== 5'b11111) begin
      n_err++;
      $display("FAIL concurrent_cleanup: free=%b want 11111", bus.free);
    end
  endtask

  task automatic test_reset_in_route();
    logic [4:0] e;
    request(3, 8'h10);
    tick();
    tick();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if ({bus.ack_h, bus.free, bus.mux_in, bus.mux_out} !== {5'b0, 5'b11111, 15'b0, 15'b0}) begin
        n_err++;
        $display("FAIL reset_route c%0d: ack=%b free=%b mux_in=%h mux_out=%h want 0 11111 0 0",
                 c, bus.ack_h, bus.free, bus.mux_in, bus.mux_out);
      end
    end
    rst_n = 1'b1;
    exp_last = NPORT - 1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      e = (c == 3) ? 5'b01000 : 5'b00000;
      n_vec++;
      if (bus.ack_h !== e) begin
        n_err++;
        $display("FAIL post_reset edge%0d: ack=%b want %b", c, bus.ack_h, e);
      end
    end
    n_vec++;
    if (mux_of(bus.mux_in, 3) != 3 || mux_of(bus.mux_out, 3) != 3 || bus.free !== 5'b10111) begin
      n_err++;
      $display("FAIL post_reset_alloc: mux_in[3]=%0d mux_out[3]=%0d free=%b want 3 3 10111",
               mux_of(bus.mux_in, 3), mux_of(bus.mux_out, 3), bus.free);
    end
    exp_last = 3;
    bus.h[3] = 1'b0;
    tick();
    bus.sender[3] = 1'b0;
    tick();
  endtask

  initial begin
    bus.h      = '0;
    bus.target = '0;
    bus.sender = '0;
    test_reset();
    test_first_grant();
    test_routing();
    test_fairness();
    test_blocking();
    test_concurrent();
    test_reset_in_route();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
